// File: rtl/turnstile_pkg.sv
// Shared lane state encoding and default sizing for the turnstile bank controller.
package turnstile_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    PENDING  = 2'd1,
    UNLOCKED = 2'd2
  } lane_state_t;

  localparam int DEF_N_LANES  = 4;
  localparam int DEF_CAPACITY = 12;
  localparam int DEF_TIMEOUT  = 8;

endpackage

// File: rtl/turnstile_bank_ctrl_if.sv
// Lane-facing bus of the turnstile bank controller.
// TURNSTILE_STATS_EN adds the entry_total / alarm_total statistics outputs.
interface turnstile_bank_ctrl_if #(
  parameter int N_LANES = 4,
  parameter int CNT_W   = 4
);
  logic [N_LANES-1:0] coin;
  logic [N_LANES-1:0] push;
  logic               exit_evt;
  logic [N_LANES-1:0] unlock;
  logic [N_LANES-1:0] refund;
  logic [N_LANES-1:0] alarm;
  logic [CNT_W-1:0]   occupancy;
  logic               full;
`ifdef TURNSTILE_STATS_EN
  logic [15:0]        entry_total;
  logic [15:0]        alarm_total;
`endif

  modport master (
    output coin, push, exit_evt,
    input  unlock, refund, alarm, occupancy, full
`ifdef TURNSTILE_STATS_EN
    , input entry_total, alarm_total
`endif
  );

  modport slave (
    input  coin, push, exit_evt,
    output unlock, refund, alarm, occupancy, full
`ifdef TURNSTILE_STATS_EN
    , output entry_total, alarm_total
`endif
  );
endinterface

// File: rtl/turnstile_lane.sv
// One turnstile lane: LOCKED/PENDING/UNLOCKED FSM, unlock timeout and
// registered refund/alarm pulses. entered/released are same-cycle strobes.
module turnstile_lane
  import turnstile_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        grant,
  input  logic        coin,
  input  logic        push,
  output lane_state_t state,
  output logic        entered,
  output logic        released,
  output logic        refund,
  output logic        alarm
);
  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(TIMEOUT);

  lane_state_t     state_q, state_nxt;
  logic [TO_W-1:0] timer_q, timer_nxt;
  logic            refund_q, refund_nxt;
  logic            alarm_q, alarm_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOCKED;
      timer_q  <= '0;
      refund_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      timer_q  <= timer_nxt;
      refund_q <= refund_nxt;
      alarm_q  <= alarm_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    timer_nxt  = timer_q;
    refund_nxt = 1'b0;
    alarm_nxt  = 1'b0;
    entered    = 1'b0;
    released   = 1'b0;
    case (state_q)
      LOCKED: begin
        if (coin) state_nxt = PENDING;
        alarm_nxt = push;
      end
      PENDING: begin
        refund_nxt = coin;
        alarm_nxt  = push;
        if (grant) begin
          state_nxt = UNLOCKED;
          timer_nxt = TIMEOUT_V;
        end
      end
      UNLOCKED: begin
        refund_nxt = coin;
        // A push in the final open cycle beats the timeout.
        if (push) begin
          state_nxt = LOCKED;
          entered   = 1'b1;
          timer_nxt = '0;
        end else if (timer_q == TO_W'(1)) begin
          state_nxt  = LOCKED;
          released   = 1'b1;
          refund_nxt = 1'b1;
          timer_nxt  = '0;
        end else begin
          timer_nxt = timer_q - TO_W'(1);
        end
      end
      default: state_nxt = LOCKED;
    endcase
  end

  assign state  = state_q;
  assign refund = refund_q;
  assign alarm  = alarm_q;

endmodule

// File: rtl/turnstile_bank_ctrl.sv
// Bank of turnstile lanes sharing one capacity budget via a round-robin arbiter.
// TURNSTILE_STATS_EN adds wrapping 16-bit entry and alarm totals.
module turnstile_bank_ctrl
  import turnstile_pkg::*;
#(
  parameter int N_LANES  = DEF_N_LANES,
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int CNT_W    = 4,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int TO_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  turnstile_bank_ctrl_if.slave bus
);
  localparam int               PTR_W = $clog2(N_LANES);
  localparam logic [CNT_W:0]   CAP_V = CAPACITY[CNT_W:0];

  lane_state_t        lane_state [N_LANES];
  logic [N_LANES-1:0] req, grant, entered, released, unlock_v, refund_v, alarm_v;
  logic [CNT_W-1:0]   occupancy_q, reserved_q, n_entered, n_released;
  logic [CNT_W-1:0]   occ_sum, occ_nxt, res_nxt;
  logic [CNT_W:0]     committed;
  logic [PTR_W-1:0]   ptr_q, grant_idx;
  logic               grant_any, budget_ok;

  function automatic logic [3:0] popcount(input logic [N_LANES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_LANES; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    turnstile_lane #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_lane (
      .clk      (clk),
      .rst_n    (reset),
      .grant    (grant[i]),
      .coin     (bus.coin[i]),
      .push     (bus.push[i]),
      .state    (lane_state[i]),
      .entered  (entered[i]),
      .released (released[i]),
      .refund   (refund_v[i]),
      .alarm    (alarm_v[i])
    );
    assign req[i]      = (lane_state[i] == PENDING);
    assign unlock_v[i] = (lane_state[i] == UNLOCKED);
  end

  assign committed = {1'b0, occupancy_q} + {1'b0, reserved_q};
  assign budget_ok = (committed < CAP_V);

  // Round-robin search from ptr_q; at most one grant, only with budget left.
  always_comb begin
    int k;
    k         = 0;
    grant     = '0;
    grant_idx = ptr_q;
    grant_any = 1'b0;
    if (budget_ok) begin
      for (int j = 0; j < N_LANES; j++) begin
        k = int'(ptr_q) + j;
        if (k >= N_LANES) k = k - N_LANES;
        if (!grant_any && req[k]) begin
          grant_any = 1'b1;
          grant_idx = PTR_W'(k);
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // Entries move a reservation into occupancy; exits saturate at zero.
  always_comb begin
    n_entered  = CNT_W'(popcount(entered));
    n_released = CNT_W'(popcount(released));
    occ_sum    = occupancy_q + n_entered;
    occ_nxt    = (bus.exit_evt && (occ_sum != '0)) ? occ_sum - CNT_W'(1) : occ_sum;
    res_nxt    = reserved_q + CNT_W'(grant_any) - n_entered - n_released;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy_q <= '0;
      reserved_q  <= '0;
      ptr_q       <= '0;
    end else begin
      occupancy_q <= occ_nxt;
      reserved_q  <= res_nxt;
      if (grant_any)
        ptr_q <= (grant_idx == PTR_W'(N_LANES - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  assign bus.unlock    = unlock_v;
  assign bus.refund    = refund_v;
  assign bus.alarm     = alarm_v;
  assign bus.occupancy = occupancy_q;
  assign bus.full      = (committed == CAP_V);

`ifdef TURNSTILE_STATS_EN
  logic [15:0] entry_total_q, alarm_total_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_total_q <= '0;
      alarm_total_q <= '0;
    end else begin
      entry_total_q <= entry_total_q + 16'(popcount(entered));
      alarm_total_q <= alarm_total_q + 16'(popcount(alarm_v));
    end
  end

  assign bus.entry_total = entry_total_q;
  assign bus.alarm_total = alarm_total_q;
`endif

endmodule
